// File: rtl/ctrl_pipeline.sv
// Control-word pipeline from Decode through STAGES register stages, with per-stage flush
// and a multicycle hold that parks an op in stage 0 while bubbling stage 1 and stalling Decode.
module ctrl_pipeline #(
    parameter int W         = 8,
    parameter int STAGES    = 3,
    parameter int MC_CYCLES = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [W-1:0]                       ctrl_d,
    input  logic                               valid_d,
    input  logic                               stall_d,
    input  logic                               mc_d,
    input  logic [STAGES-1:0]                  flush,
    output logic [STAGES*W-1:0]                ctrl_q,
    output logic [STAGES-1:0]                  valid_q,
    output logic                               hold_d,
    output logic [$clog2(MC_CYCLES+1)-1:0]     mc_count
);
    localparam int CW = $clog2(MC_CYCLES + 1);
    localparam logic [CW-1:0] MC_RELOAD = CW'(MC_CYCLES - 1);

    logic [STAGES-1:0][W-1:0] ctrlReg;
    logic [STAGES-1:0][W-1:0] ctrlNext;
    logic [STAGES-1:0]        validReg;
    logic [STAGES-1:0]        validNext;
    logic [CW-1:0]            mcCountReg;
    logic [CW-1:0]            mcCountNext;
    logic                     busy;

    // Derived only from the counter register so hold_d has no combinational input path.
    assign busy     = (mcCountReg != '0);
    assign hold_d   = busy;
    assign mc_count = mcCountReg;
    assign ctrl_q   = ctrlReg;
    assign valid_q  = validReg;

    always_comb begin
        ctrlNext[0]  = ctrlReg[0];
        validNext[0] = validReg[0];
        mcCountNext  = mcCountReg;
        if (flush[0]) begin
            ctrlNext[0]  = '0;
            validNext[0] = 1'b0;
            mcCountNext  = '0;
        end else if (busy) begin
            mcCountNext  = mcCountReg - 1'b1;
        end else if (stall_d) begin
            ctrlNext[0]  = '0;
            validNext[0] = 1'b0;
        end else begin
            ctrlNext[0]  = ctrl_d;
            validNext[0] = valid_d;
            mcCountNext  = (valid_d && mc_d) ? MC_RELOAD : '0;
        end
    end

    // Stage 1 also bubbles while the multicycle op is parked upstream.
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        logic kill;
        if (gi == 1) begin : g_first
            assign kill = flush[gi] | busy;
        end else begin : g_rest
            assign kill = flush[gi];
        end
        assign ctrlNext[gi]  = kill ? '0 : ctrlReg[gi-1];
        assign validNext[gi] = kill ? 1'b0 : validReg[gi-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrlReg    <= '0;
            validReg   <= '0;
            mcCountReg <= '0;
        end else begin
            ctrlReg    <= ctrlNext;
            validReg   <= validNext;
            mcCountReg <= mcCountNext;
        end
    end
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed plus random stimulus for ctrl_pipeline, checked each cycle against a stage-list model.
module tb_ctrl_pipeline;
    localparam int W = 8;
    localparam int STAGES = 3;
    localparam int MC_CYCLES = 4;
    localparam int CW = $clog2(MC_CYCLES + 1);

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [W-1:0]         ctrl_d = '0;
    logic                 valid_d = 1'b0;
    logic                 stall_d = 1'b0;
    logic                 mc_d = 1'b0;
    logic [STAGES-1:0]    flush = '0;
    logic [STAGES*W-1:0]  ctrl_q;
    logic [STAGES-1:0]    valid_q;
    logic                 hold_d;
    logic [CW-1:0]        mc_count;

    int total = 0;
    int bad = 0;

    // Reference: list of (word, valid) per stage plus remaining extra cycles of the op in stage 0.
    logic [W-1:0] mWord [STAGES];
    logic         mValid [STAGES];
    int           mRemain;

    ctrl_pipeline #(.W(W), .STAGES(STAGES), .MC_CYCLES(MC_CYCLES)) dut (
        .clk(clk), .reset(reset), .ctrl_d(ctrl_d), .valid_d(valid_d), .stall_d(stall_d),
        .mc_d(mc_d), .flush(flush), .ctrl_q(ctrl_q), .valid_q(valid_q), .hold_d(hold_d),
        .mc_count(mc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < STAGES; i++) begin
            mWord[i] = '0;
            mValid[i] = 1'b0;
        end
        mRemain = 0;
    endtask

    task automatic modelEdge(input logic [W-1:0] c, input logic v, input logic s, input logic m,
                             input logic [STAGES-1:0] f);
        logic [W-1:0] oldWord [STAGES];
        logic         oldValid [STAGES];
        bit           wasBusy;
        wasBusy = (mRemain > 0);
        for (int i = 0; i < STAGES; i++) begin
            oldWord[i] = mWord[i];
            oldValid[i] = mValid[i];
        end
        for (int i = 1; i < STAGES; i++) begin
            if (f[i] || (i == 1 && wasBusy)) begin
                mWord[i] = '0;
                mValid[i] = 1'b0;
            end else begin
                mWord[i] = oldWord[i-1];
                mValid[i] = oldValid[i-1];
            end
        end
        if (f[0]) begin
            mWord[0] = '0;
            mValid[0] = 1'b0;
            mRemain = 0;
        end else if (wasBusy) begin
            mRemain = mRemain - 1;
        end else if (s) begin
            mWord[0] = '0;
            mValid[0] = 1'b0;
        end else begin
            mWord[0] = c;
            mValid[0] = v;
            mRemain = (v && m) ? MC_CYCLES - 1 : 0;
        end
    endtask

    task automatic checkAll(input string tag);
        logic [STAGES*W-1:0] expCtrl;
        logic [STAGES-1:0]   expValid;
        for (int i = 0; i < STAGES; i++) begin
            expCtrl[i*W +: W] = mWord[i];
            expValid[i] = mValid[i];
        end
        chk({tag, ".ctrl_q"}, 32'(ctrl_q), 32'(expCtrl));
        chk({tag, ".valid_q"}, 32'(valid_q), 32'(expValid));
        chk({tag, ".hold_d"}, 32'(hold_d), 32'(mRemain > 0));
        chk({tag, ".mc_count"}, 32'(mc_count), 32'(mRemain));
    endtask

    task automatic step(input string tag, input logic [W-1:0] c, input logic v, input logic s,
                        input logic m, input logic [STAGES-1:0] f);
        ctrl_d = c;
        valid_d = v;
        stall_d = s;
        mc_d = m;
        flush = f;
        @(posedge clk);
        modelEdge(c, v, s, m, f);
        #1;
        checkAll(tag);
    endtask

    initial begin
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        chk("reset.ctrl_q_zero", 32'(ctrl_q), 32'h0);
        #3 reset = 1'b1;

        // Five back-to-back valid words.
        for (int k = 0; k < 5; k++) begin
            step("stream", W'(8'h11 + k), 1'b1, 1'b0, 1'b0, '0);
            if (k == 2) begin
                chk("stream.full_valid", 32'(valid_q), 32'b111);
                chk("stream.stage2_first", 32'(ctrl_q[2*W +: W]), 32'h11);
            end
        end

        // Single-cycle stall mid-stream.
        step("stall.pre", 8'h21, 1'b1, 1'b0, 1'b0, '0);
        step("stall", 8'h22, 1'b1, 1'b1, 1'b0, '0);
        chk("stall.bubble_s0", 32'({valid_q[0], ctrl_q[0 +: W]}), 32'h0);
        step("stall.post", 8'h23, 1'b1, 1'b0, 1'b0, '0);
        step("stall.drain", 8'h24, 1'b1, 1'b0, 1'b0, '0);
        chk("stall.bubble_s2", 32'({valid_q[2], ctrl_q[2*W +: W]}), 32'h0);

        // Multicycle op 0xA5; Decode keeps presenting 0x5A which must wait.
        step("mc.load", 8'hA5, 1'b1, 1'b0, 1'b1, '0);
        chk("mc.count3", 32'(mc_count), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("mc.hold_high", 32'(hold_d), 32'd1);
            step("mc.hold", 8'h5A, 1'b1, 1'b0, 1'b0, '0);
            chk("mc.count_dn", 32'(mc_count), 32'(2 - k));
            chk("mc.s1_bubble", 32'({valid_q[1], ctrl_q[W +: W]}), 32'h0);
        end
        chk("mc.hold_low", 32'(hold_d), 32'd0);
        step("mc.leave", 8'h5A, 1'b1, 1'b0, 1'b0, '0);
        chk("mc.s1_op", 32'(ctrl_q[W +: W]), 32'hA5);
        chk("mc.s0_next", 32'(ctrl_q[0 +: W]), 32'h5A);

        // Abort a multicycle op with flush[0] while mc_count = 2.
        step("abort.load", 8'hC3, 1'b1, 1'b0, 1'b1, '0);
        step("abort.wait", 8'h33, 1'b1, 1'b0, 1'b0, '0);
        chk("abort.count2", 32'(mc_count), 32'd2);
        step("abort.flush", 8'h33, 1'b1, 1'b0, 1'b0, 3'b001);
        chk("abort.s0_bubble", 32'({valid_q[0], ctrl_q[0 +: W]}), 32'h0);
        chk("abort.s1_bubble", 32'({valid_q[1], ctrl_q[W +: W]}), 32'h0);
        chk("abort.count0", 32'(mc_count), 32'd0);

        // Fill the pipe, then flush only stage 2.
        for (int k = 0; k < 3; k++) step("fill", W'(8'h41 + k), 1'b1, 1'b0, 1'b0, '0);
        step("flush2", 8'h44, 1'b1, 1'b0, 1'b0, 3'b100);
        chk("flush2.s2_bubble", 32'(valid_q[2]), 32'd0);
        chk("flush2.s1_adv", 32'(ctrl_q[W +: W]), 32'h43);
        step("flush2.after", 8'h45, 1'b1, 1'b0, 1'b0, '0);
        chk("flush2.s2_refill", 32'(ctrl_q[2*W +: W]), 32'h43);

        // Asynchronous reset in the middle of a multicycle op.
        step("areset.load", 8'h77, 1'b1, 1'b0, 1'b1, '0);
        step("areset.hold", 8'h78, 1'b1, 1'b0, 1'b0, '0);
        #2 reset = 1'b0;
        #1;
        modelClear();
        checkAll("areset.async");
        chk("areset.hold_drop", 32'(hold_d), 32'd0);
        #1 reset = 1'b1;
        step("areset.resume", 8'h79, 1'b1, 1'b0, 1'b0, '0);
        chk("areset.s0_load", 32'(ctrl_q[0 +: W]), 32'h79);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            logic [STAGES-1:0] f;
            f = ($urandom_range(0, 7) == 0) ? STAGES'($urandom) : '0;
            step("rand", W'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0), f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
